// File: rtl/fwd_pipe_unit_if.sv
// rtl/fwd_pipe_unit_if.sv - issue/load/read/write-back bundle for fwd_pipe_unit
//
// Signals carry the unit-relative _i/_o suffixes:
//   iss_valid_i, iss_rd_i, iss_dv_i, iss_data_i : producer register write issue
//   ld_ret_i, ld_data_i                         : load data return
//   flush_i                                     : kill in-flight entries
//   rd_addr_i, rf_data_i, rd_data_o             : packed read ports
//   stall_o                                     : issue not accepted
//   wb_valid_o, wb_addr_o, wb_data_o            : regfile write-back
// master: pipeline side driving the unit; slave: the unit itself.

interface fwd_pipe_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2
);
  logic                     iss_valid_i;
  logic [REG_AW-1:0]        iss_rd_i;
  logic                     iss_dv_i;
  logic [XLEN-1:0]          iss_data_i;
  logic                     ld_ret_i;
  logic [XLEN-1:0]          ld_data_i;
  logic                     flush_i;
  logic [NUM_RD*REG_AW-1:0] rd_addr_i;
  logic [NUM_RD*XLEN-1:0]   rf_data_i;
  logic [NUM_RD*XLEN-1:0]   rd_data_o;
  logic                     stall_o;
  logic                     wb_valid_o;
  logic [REG_AW-1:0]        wb_addr_o;
  logic [XLEN-1:0]          wb_data_o;

  modport master (
    output iss_valid_i, iss_rd_i, iss_dv_i, iss_data_i,
    output ld_ret_i, ld_data_i, flush_i, rd_addr_i, rf_data_i,
    input  rd_data_o, stall_o, wb_valid_o, wb_addr_o, wb_data_o
  );

  modport slave (
    input  iss_valid_i, iss_rd_i, iss_dv_i, iss_data_i,
    input  ld_ret_i, ld_data_i, flush_i, rd_addr_i, rf_data_i,
    output rd_data_o, stall_o, wb_valid_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/fwd_pipe_unit.sv
// rtl/fwd_pipe_unit.sv - operand forwarding and load-use interlock unit
//
// Tracks DEPTH in-flight register writes (entry 0 youngest) plus a write-back
// register, forwards the youngest available value to NUM_RD read ports and
// stalls the issuer while a needed load result is still outstanding.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : fwd_pipe_unit_if.slave (issue, load return, flush, reads, write-back)

module fwd_pipe_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
) (
  input  logic            clk,
  input  logic            rst,
  fwd_pipe_unit_if.slave  bus
);

  logic              r_vld  [DEPTH];
  logic [REG_AW-1:0] r_rd   [DEPTH];
  logic              r_dv   [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];

  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_addr;
  logic [XLEN-1:0]   r_wb_data;

  logic [DEPTH-1:0]       w_fill_sel;
  logic                   w_ld_ok;
  logic                   w_dv   [DEPTH];
  logic [XLEN-1:0]        w_data [DEPTH];
  logic                   w_freeze;
  logic [NUM_RD-1:0]      w_port_stall;
  logic [NUM_RD*XLEN-1:0] w_rd_data;
  logic                   w_stall;
  logic                   w_accept;

  // A flush drops any same-cycle load return.
  assign w_ld_ok = bus.ld_ret_i && !bus.flush_i;

  // Pick the oldest pending load; later (older) indices overwrite earlier ones.
  always_comb begin
    w_fill_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[k] && !r_dv[k]) begin
        w_fill_sel    = '0;
        w_fill_sel[k] = 1'b1;
      end
    end
  end

  // Post-fill view of the entries: used for stall, forwarding and the shift.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_dv[k]   = r_dv[k];
      w_data[k] = r_data[k];
      if (w_ld_ok && w_fill_sel[k]) begin
        w_dv[k]   = 1'b1;
        w_data[k] = bus.ld_data_i;
      end
    end
  end

  // An unfilled load at the oldest slot cannot retire, so everything holds.
  assign w_freeze = r_vld[DEPTH-1] && !w_dv[DEPTH-1];

  always_comb begin : read_ports
    logic [REG_AW-1:0] a;
    logic              hit;
    logic              hit_dv;
    logic              fwd_hit;
    logic [XLEN-1:0]   fwd;
    w_port_stall = '0;
    w_rd_data    = '0;
    a       = '0;
    hit     = 1'b0;
    hit_dv  = 1'b0;
    fwd_hit = 1'b0;
    fwd     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a       = bus.rd_addr_i[p*REG_AW +: REG_AW];
      hit     = 1'b0;
      hit_dv  = 1'b0;
      fwd_hit = 1'b0;
      fwd     = '0;
      // Scan oldest to youngest so the youngest match is left standing.
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (r_vld[k] && (r_rd[k] == a)) begin
          hit    = 1'b1;
          hit_dv = w_dv[k];
          if (w_dv[k]) begin
            fwd_hit = 1'b1;
            fwd     = w_data[k];
          end
        end
      end
      w_port_stall[p] = (a != '0) && hit && !hit_dv;
      if (a == '0) begin
        w_rd_data[p*XLEN +: XLEN] = '0;
      end else if (fwd_hit) begin
        w_rd_data[p*XLEN +: XLEN] = fwd;
      end else if (r_wb_valid && (r_wb_addr == a)) begin
        w_rd_data[p*XLEN +: XLEN] = r_wb_data;
      end else begin
        w_rd_data[p*XLEN +: XLEN] = bus.rf_data_i[p*XLEN +: XLEN];
      end
    end
  end

  assign w_stall  = w_freeze || (|w_port_stall);
  assign w_accept = bus.iss_valid_i && !w_stall && !bus.flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_vld[k]  <= 1'b0;
        r_rd[k]   <= '0;
        r_dv[k]   <= 1'b0;
        r_data[k] <= '0;
      end
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      if (!w_freeze) begin
        // x0 writes retire through wb but never enable the regfile write.
        r_wb_valid <= r_vld[DEPTH-1] && (r_rd[DEPTH-1] != '0);
        r_wb_addr  <= r_rd[DEPTH-1];
        r_wb_data  <= w_data[DEPTH-1];
        for (int k = DEPTH-1; k >= 1; k--) begin
          r_vld[k]  <= r_vld[k-1];
          r_rd[k]   <= r_rd[k-1];
          r_dv[k]   <= w_dv[k-1];
          r_data[k] <= w_data[k-1];
        end
        r_vld[0]  <= w_accept;
        r_rd[0]   <= bus.iss_rd_i;
        r_dv[0]   <= bus.iss_dv_i;
        r_data[0] <= bus.iss_data_i;
      end else begin
        r_wb_valid <= 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          r_dv[k]   <= w_dv[k];
          r_data[k] <= w_data[k];
        end
      end
      if (bus.flush_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_vld[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.rd_data_o  = w_rd_data;
  assign bus.stall_o    = w_stall;
  assign bus.wb_valid_o = r_wb_valid;
  assign bus.wb_addr_o  = r_wb_addr;
  assign bus.wb_data_o  = r_wb_data;

endmodule

// File: tb/tb_fwd_pipe_unit.sv
// tb/tb_fwd_pipe_unit.sv - self-checking bench for fwd_pipe_unit
module tb_fwd_pipe_unit;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam logic [31:0] RF0 = 32'hAAAA0000;
  localparam logic [31:0] RF1 = 32'hBBBB0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  fwd_pipe_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_RD(NUM_RD)) bus ();

  fwd_pipe_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_RD(NUM_RD), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        dv;
    logic [31:0] d;
  } ent_t;

  // Model: m_e[age], age 0 = most recently issued instruction.
  ent_t        m_e [DEPTH];
  ent_t        m_f [DEPTH];
  logic        m_wbv = 1'b0;
  logic [4:0]  m_wba = '0;
  logic [31:0] m_wbd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] addr_of(input int p);
    logic [NUM_RD*REG_AW-1:0] v;
    v = bus.rd_addr_i;
    return v[p*REG_AW +: REG_AW];
  endfunction

  function automatic logic [31:0] dut_rd(input int p);
    logic [NUM_RD*XLEN-1:0] v;
    v = bus.rd_data_o;
    return v[p*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] rf_of(input int p);
    logic [NUM_RD*XLEN-1:0] v;
    v = bus.rf_data_i;
    return v[p*XLEN +: XLEN];
  endfunction

  // Load return lands in the oldest instruction still waiting for data.
  function automatic void model_fill();
    for (int k = 0; k < DEPTH; k++) m_f[k] = m_e[k];
    if (bus.ld_ret_i && !bus.flush_i) begin
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (m_f[k].v && !m_f[k].dv) begin
          m_f[k].dv = 1'b1;
          m_f[k].d  = bus.ld_data_i;
          break;
        end
      end
    end
  endfunction

  function automatic logic m_frozen();
    return m_f[DEPTH-1].v && !m_f[DEPTH-1].dv;
  endfunction

  function automatic logic m_port_stall(input int p);
    logic [4:0] a;
    a = addr_of(p);
    if (a == 0) return 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if (m_f[k].v && m_f[k].rd == a) return !m_f[k].dv;
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    logic s;
    s = m_frozen();
    for (int p = 0; p < NUM_RD; p++) s = s | m_port_stall(p);
    return s;
  endfunction

  function automatic logic [31:0] m_fwd(input int p);
    logic [4:0] a;
    a = addr_of(p);
    if (a == 0) return 32'h0;
    for (int k = 0; k < DEPTH; k++)
      if (m_f[k].v && m_f[k].rd == a && m_f[k].dv) return m_f[k].d;
    if (m_wbv && m_wba == a) return m_wbd;
    return rf_of(p);
  endfunction

  always @(posedge clk) begin
    logic frz;
    logic st;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_e[k] = '0;
      m_wbv = 1'b0;
      m_wba = '0;
      m_wbd = '0;
    end else begin
      model_fill();
      frz = m_frozen();
      st  = m_stall();
      if (!frz) begin
        m_wbv = m_f[DEPTH-1].v && (m_f[DEPTH-1].rd != 0);
        m_wba = m_f[DEPTH-1].rd;
        m_wbd = m_f[DEPTH-1].d;
        for (int k = DEPTH-1; k >= 1; k--) m_e[k] = m_f[k-1];
        m_e[0].v  = bus.iss_valid_i && !st && !bus.flush_i;
        m_e[0].rd = bus.iss_rd_i;
        m_e[0].dv = bus.iss_dv_i;
        m_e[0].d  = bus.iss_data_i;
      end else begin
        m_wbv = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_e[k] = m_f[k];
      end
      if (bus.flush_i)
        for (int k = 0; k < DEPTH; k++) m_e[k].v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      model_fill();
      for (int p = 0; p < NUM_RD; p++)
        chk($sformatf("model_rd_data_p%0d", p), dut_rd(p), m_fwd(p));
      chk("model_stall", {31'h0, bus.stall_o}, {31'h0, m_stall()});
      chk("model_wb_valid", {31'h0, bus.wb_valid_o}, {31'h0, m_wbv});
      if (m_wbv) begin
        chk("model_wb_addr", {27'h0, bus.wb_addr_o}, {27'h0, m_wba});
        chk("model_wb_data", bus.wb_data_o, m_wbd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid_i = 1'b0;
    bus.iss_rd_i    = '0;
    bus.iss_dv_i    = 1'b0;
    bus.iss_data_i  = '0;
    bus.ld_ret_i    = 1'b0;
    bus.ld_data_i   = '0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic dv, input logic [31:0] d);
    bus.iss_valid_i = 1'b1;
    bus.iss_rd_i    = rd;
    bus.iss_dv_i    = dv;
    bus.iss_data_i  = d;
  endtask

  task automatic setrd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr_i = {a1, a0};
  endtask

  initial begin
    idle();
    setrd(0, 0);
    bus.rf_data_i = {RF1, RF0};
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_wb_valid", {31'h0, bus.wb_valid_o}, 32'h0);
    chk("reset_wb_addr", {27'h0, bus.wb_addr_o}, 32'h0);
    chk("reset_wb_data", bus.wb_data_o, 32'h0);
    chk("reset_stall", {31'h0, bus.stall_o}, 32'h0);

    // Single ALU result forwarded the next cycle.
    issue(5, 1, 32'h11);
    step();
    idle();
    setrd(5, 0);
    #1;
    chk("t1_rd0", dut_rd(0), 32'h11);
    chk("t1_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("t1_rd1_x0", dut_rd(1), 32'h0);
    repeat (5) step();

    // Duplicate destination: younger wins, even after older writes back.
    issue(5, 1, 32'h11);
    step();
    issue(5, 1, 32'h22);
    step();
    idle();
    setrd(5, 0);
    #1;
    chk("t2_young", dut_rd(0), 32'h22);
    step();
    step();
    #1;
    chk("t2_wb_valid", {31'h0, bus.wb_valid_o}, 32'h1);
    chk("t2_wb_data", bus.wb_data_o, 32'h11);
    chk("t2_rd_after_wb", dut_rd(0), 32'h22);
    repeat (4) step();

    // Load-use stall with bubbles, released by a same-cycle fill.
    issue(7, 0, 32'h0);
    step();
    issue(9, 1, 32'h99);
    setrd(7, 0);
    #1;
    chk("t3_stall", {31'h0, bus.stall_o}, 32'h1);
    step();
    #1;
    chk("t3_stall_hold", {31'h0, bus.stall_o}, 32'h1);
    bus.ld_ret_i  = 1'b1;
    bus.ld_data_i = 32'hABCD;
    #1;
    chk("t3_fill_rd0", dut_rd(0), 32'hABCD);
    chk("t3_fill_stall", {31'h0, bus.stall_o}, 32'h0);
    step();
    idle();
    repeat (5) step();

    // Load reaches the oldest slot unfilled: freeze until it returns.
    issue(6, 1, 32'h66);
    step();
    issue(7, 0, 32'h0);
    step();
    idle();
    setrd(7, 6);
    step();
    step();
    #1;
    chk("t4_wb6_valid", {31'h0, bus.wb_valid_o}, 32'h1);
    chk("t4_wb6_addr", {27'h0, bus.wb_addr_o}, 32'h6);
    chk("t4_wb_fwd", dut_rd(1), 32'h66);
    chk("t4_freeze", {31'h0, bus.stall_o}, 32'h1);
    step();
    #1;
    chk("t4_frz_wbv", {31'h0, bus.wb_valid_o}, 32'h0);
    chk("t4_frz_stall", {31'h0, bus.stall_o}, 32'h1);
    step();
    #1;
    chk("t4_frz_stall2", {31'h0, bus.stall_o}, 32'h1);
    bus.ld_ret_i  = 1'b1;
    bus.ld_data_i = 32'h7777;
    #1;
    chk("t4_release_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("t4_release_rd0", dut_rd(0), 32'h7777);
    step();
    idle();
    #1;
    chk("t4_wb7_valid", {31'h0, bus.wb_valid_o}, 32'h1);
    chk("t4_wb7_addr", {27'h0, bus.wb_addr_o}, 32'h7);
    chk("t4_wb7_data", bus.wb_data_o, 32'h7777);
    repeat (4) step();

    // x0 in flight never forwards; two ports see their own producers.
    issue(0, 1, 32'h55);
    step();
    issue(3, 1, 32'h33);
    step();
    issue(4, 1, 32'h44);
    step();
    idle();
    setrd(0, 3);
    #1;
    chk("t5_x0", dut_rd(0), 32'h0);
    chk("t5_p1_x3", dut_rd(1), 32'h33);
    setrd(3, 4);
    #1;
    chk("t5_p0_x3", dut_rd(0), 32'h33);
    chk("t5_p1_x4", dut_rd(1), 32'h44);
    step();
    #1;
    chk("t5_wb_x0", {31'h0, bus.wb_valid_o}, 32'h0);
    repeat (4) step();

    // Flush with three valid entries; oldest still written back.
    issue(10, 1, 32'hA0);
    step();
    issue(11, 1, 32'hA1);
    step();
    issue(12, 1, 32'hA2);
    step();
    issue(13, 1, 32'hA3);
    bus.flush_i   = 1'b1;
    bus.ld_ret_i  = 1'b1;
    bus.ld_data_i = 32'hDEAD;
    step();
    idle();
    setrd(11, 12);
    #1;
    chk("t6_wb_valid", {31'h0, bus.wb_valid_o}, 32'h1);
    chk("t6_wb_addr", {27'h0, bus.wb_addr_o}, 32'd10);
    chk("t6_wb_data", bus.wb_data_o, 32'hA0);
    chk("t6_rd0_rf", dut_rd(0), RF0);
    chk("t6_rd1_rf", dut_rd(1), RF1);
    chk("t6_stall", {31'h0, bus.stall_o}, 32'h0);
    step();
    #1;
    chk("t6_wb_empty", {31'h0, bus.wb_valid_o}, 32'h0);
    bus.ld_ret_i  = 1'b1;
    bus.ld_data_i = 32'hBEEF;
    setrd(13, 0);
    step();
    idle();
    #1;
    chk("t6_stray_rd0", dut_rd(0), RF0);
    chk("t6_stray_wbv", {31'h0, bus.wb_valid_o}, 32'h0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
